// File: rtl/regfile_dump_ctrl.sv
// Debug-side register file dump controller: halts the core, sweeps read port 1 and
// streams each register over valid/ready. DUMP_SKIP_X0_EN starts the sweep at x1.
module regfile_dump_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      halt_req,
   input  logic                      halt_ack,
   output logic                      rf_read_enable,
   output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
   input  logic [DATA_WIDTH-1:0]     rf_rs1,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [REG_ADDR_WIDTH-1:0] out_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HALT = 3'd1;
   localparam logic [2:0] ST_READ = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

`ifdef DUMP_SKIP_X0_EN
   localparam logic [REG_ADDR_WIDTH-1:0] FIRST_IDX = REG_ADDR_WIDTH'(1);
`else
   localparam logic [REG_ADDR_WIDTH-1:0] FIRST_IDX = '0;
`endif
   localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = '1;
   localparam logic [REG_ADDR_WIDTH-1:0] IDX_ONE  = REG_ADDR_WIDTH'(1);

   logic [2:0]                state;
   logic [2:0]                next_state;
   logic [REG_ADDR_WIDTH-1:0] idx;
   logic                      abort_q;
   logic                      abort_now;
   logic                      word_taken;

   // Losing halt_ack in READ/SEND ends the dump; the pending word is discarded.
   assign abort_now  = ((state == ST_READ) || (state == ST_SEND)) && !halt_ack;
   assign word_taken = (state == ST_SEND) && out_ready;

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (start) next_state = ST_HALT;
         ST_HALT: if (halt_ack) next_state = ST_READ;
         ST_READ: next_state = abort_now ? ST_DONE : ST_SEND;
         ST_SEND: begin
            if (abort_now) begin
               next_state = ST_DONE;
            end else if (word_taken) begin
               next_state = (idx == LAST_IDX) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         abort_q  <= 1'b0;
         out_data <= '0;
         out_addr <= '0;
      end else begin
         state <= next_state;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx     <= FIRST_IDX;
                  abort_q <= 1'b0;
               end
            end
            ST_READ: begin
               if (abort_now) begin
                  abort_q <= 1'b1;
               end else begin
                  out_data <= rf_rs1;
                  out_addr <= idx;
               end
            end
            ST_SEND: begin
               if (abort_now) begin
                  abort_q <= 1'b1;
               end else if (word_taken && (idx != LAST_IDX)) begin
                  idx <= idx + IDX_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset drops halt_req at once.
   assign halt_req       = (state == ST_HALT) || (state == ST_READ) || (state == ST_SEND);
   assign rf_read_enable = (state == ST_READ);
   assign rf_rs1_addr    = (state == ST_READ) ? idx : '0;
   assign out_valid      = (state == ST_SEND);
   assign busy           = (state != ST_IDLE);
   assign done           = (state == ST_DONE);
   assign aborted        = (state == ST_DONE) && abort_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: stimulus queues expected words from a
// register-file model, an independent negedge monitor pops and compares them.
module tb_regfile_dump_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
`ifdef DUMP_SKIP_X0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          halt_req;
   logic          halt_ack;
   logic          rf_read_enable;
   logic [AW-1:0] rf_rs1_addr;
   logic [DW-1:0] rf_rs1;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          busy;
   logic          done;
   logic          aborted;

   logic [DW-1:0] mem [32];
   word_t         exp_q [$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            done_cnt = 0;

   regfile_dump_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_read_enable(rf_read_enable), .rf_rs1_addr(rf_rs1_addr), .rf_rs1(rf_rs1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // Register file model: combinational read, x0 hardwired to zero.
   always_comb rf_rs1 = (rf_rs1_addr == '0) ? '0 : mem[rf_rs1_addr];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_halt_req"}, DW'(halt_req), 0);
      check({tag, "_rf_read_enable"}, DW'(rf_read_enable), 0);
      check({tag, "_rf_rs1_addr"}, DW'(rf_rs1_addr), 0);
      check({tag, "_out_valid"}, DW'(out_valid), 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_addr"}, DW'(out_addr), 0);
      check({tag, "_busy"}, DW'(busy), 0);
      check({tag, "_done"}, DW'(done), 0);
      check({tag, "_aborted"}, DW'(aborted), 0);
   endtask

   // Monitor: pops on every handshake and checks words stay put while stalled.
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   always @(negedge clk) begin
      word_t w;
      if (!rst) begin
         if (done) done_cnt++;
         if (prev_hold && !done) begin
            check("stall_valid_held", DW'(out_valid), 1);
            check("stall_data_held", out_data, prev_data);
            check("stall_addr_held", DW'(out_addr), DW'(prev_addr));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word_addr", DW'(out_addr), 32'hFFFF_FFFF);
            end else begin
               w = exp_q.pop_front();
               check("word_addr", DW'(out_addr), DW'(w.addr));
               check("word_data", out_data, w.data);
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_addr = out_addr;
      end else begin
         prev_hold = 1'b0;
      end
   end

   // mode: 0 ready high, 1 random ready, 2 ready low for 3 cycles while x2 is offered.
   task automatic run_dump(input int mode, input bit delay_ack, input int abort_at,
                           input bit pulse_mid, input int rst_at);
      int    last_word;
      int    active;
      int    stall;
      int    done_before;
      bit    finished;
      word_t w;
      last_word = (abort_at >= 0) ? abort_at - 1 : 31;
      for (int i = FIRST; i <= last_word; i++) begin
         w.addr = AW'(i);
         w.data = (i == 0) ? '0 : mem[i];
         exp_q.push_back(w);
      end
      done_before = done_cnt;
      active = 0;
      stall = 0;
      finished = 0;
      @(posedge clk); #1;
      start = 1'b1;
      if (delay_ack) halt_ack = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", DW'(busy), 1);
      check("halt_req_after_start", DW'(halt_req), 1);
      if (delay_ack) begin
         for (int k = 0; k < 5; k++) begin
            check("wait_ack_halt_req", DW'(halt_req), 1);
            check("wait_ack_read_en", DW'(rf_read_enable), 0);
            check("wait_ack_valid", DW'(out_valid), 0);
            @(posedge clk); #1;
         end
         halt_ack = 1'b1;
      end
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("async_rst");
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            check("no_done_on_reset", DW'(done_cnt), DW'(done_before));
            finished = 1;
         end else if (done) begin
            check("done_aborted", DW'(aborted), (abort_at >= 0) ? 1 : 0);
            check("done_valid_low", DW'(out_valid), 0);
            check("done_halt_req_low", DW'(halt_req), 0);
            check("queue_drained", DW'(exp_q.size()), 0);
            if (mode == 0 && abort_at < 0)
               check("read_to_done_cycles", DW'(active), DW'(2 * (32 - FIRST)));
            if (mode == 2) check("x2_stall_cycles", DW'(stall), 3);
            @(posedge clk); #1;
            check("done_one_cycle", DW'(done), 0);
            check("busy_low_after_done", DW'(busy), 0);
            check("single_done_pulse", DW'(done_cnt), DW'(done_before + 1));
            halt_ack = 1'b1;
            if (pulse_mid) begin
               repeat (5) @(posedge clk);
               #1 check("no_queued_dump", DW'(busy), 0);
            end
            finished = 1;
         end else begin
            if (rf_read_enable || out_valid) active++;
            case (mode)
               1: out_ready = ($urandom_range(0, 3) != 0);
               2: begin
                  if (out_valid && out_addr == AW'(2) && stall < 3) begin
                     out_ready = 1'b0;
                     stall++;
                  end else begin
                     out_ready = 1'b1;
                  end
               end
               default: out_ready = 1'b1;
            endcase
            if (abort_at >= 0 && out_valid && out_addr == AW'(abort_at)) begin
               halt_ack = 1'b0;
               out_ready = 1'b0;
            end
            start = (pulse_mid && cyc == 8);
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      if (!finished) begin
         check("dump_timeout", 0, 1);
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      halt_ack = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      mem[1]  = 32'h1234_5678;
      mem[2]  = 32'hAABB_CCDD;
      mem[31] = 32'h5555_AAAA;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      rst = 1'b0;

      run_dump(0, 0, -1, 0, -1);
      run_dump(2, 0, -1, 0, -1);
      run_dump(0, 1, -1, 0, -1);
      run_dump(0, 0, 4, 0, -1);
      #1 check("idle_after_abort", DW'(busy), 0);
      run_dump(0, 0, -1, 1, -1);
      run_dump(0, 0, -1, 0, 20);
      run_dump(0, 0, -1, 0, -1);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = $urandom;
         run_dump(1, 0, -1, 0, -1);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Debug-side reader for the rv32i register file: on a start pulse it stalls the core, sweeps the architectural registers through read port 1, and streams each value out over a valid/ready interface. Sits between `register_file` (read port 1, muxed in while the core is halted) and the debug/UART transport. One-shot, FSM-controlled, one register in flight at a time.

## Interface
- `DATA_WIDTH`, 32, register and stream data width (from `rv32i_params.vh`)
- `REG_ADDR_WIDTH`, 5, register index width (from `rv32i_params.vh`)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE
- `halt_req`  out  1  asks the core pipeline to stall and release read port 1
- `halt_ack`  in  1  core is stalled; must stay high for the whole dump
- `rf_read_enable`  out  1  drives `register_file.read_enable`
- `rf_rs1_addr`  out  REG_ADDR_WIDTH  drives `register_file.rs1_addr`
- `rf_rs1`  in  DATA_WIDTH  from `register_file.rs1`; combinational read
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  stream sink ready
- `out_data`  out  DATA_WIDTH  register value
- `out_addr`  out  REG_ADDR_WIDTH  register index of `out_data`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of dump
- `aborted`  out  1  qualifies `done`: dump ended early

## Operation
- States: IDLE, HALT, READ, SEND, DONE.
- IDLE: `start`=1 -> HALT; index loaded with first register (0, or 1 under the macro).
- HALT: `halt_req`=1; `halt_ack`=1 -> READ; otherwise wait indefinitely.
- READ: `rf_read_enable`=1, `rf_rs1_addr`=index; at the edge `rf_rs1` is latched into `out_data`, index into `out_addr` -> SEND.
- SEND: `out_valid`=1, `out_data`/`out_addr` held stable. On `out_valid && out_ready`: index==31 -> DONE, else index+1 -> READ.
- DONE: `done`=1 one cycle, `halt_req`=0 -> IDLE.
- Abort: `halt_ack`=0 sampled in READ or SEND -> DONE with `aborted`=1; the pending word is dropped (`out_valid` low in DONE).
- `halt_req` high in HALT, READ, SEND; low in IDLE and DONE.
- `rf_read_enable` and `rf_rs1_addr` are 0 outside READ so the core's mux sees an idle port.
- Index is REG_ADDR_WIDTH bits; never wraps, termination is the explicit ==31 compare.
- `start` outside IDLE is ignored (no queuing).

## Timing
- Reset values: `halt_req`, `rf_read_enable`, `out_valid`, `busy`, `done`, `aborted` = 0; `rf_rs1_addr`, `out_addr`, `out_data` = 0; state IDLE. Async reset mid-dump drops `halt_req` immediately, no `done` pulse.
- `start` at edge N -> `halt_req`, `busy` high from N+1.
- `halt_ack` sampled high at edge M -> READ during M..M+1, `out_valid` high from M+2.
- Minimum 2 cycles per register (READ + SEND) with `out_ready` tied high; full 32-word dump = 64 cycles from first READ to DONE.
- Backpressure: each cycle `out_ready`=0 in SEND adds one cycle; no data change while stalled.
- `done` asserted exactly one cycle; `busy` low the cycle after DONE; new `start` accepted that same cycle.

## Configuration
- `DUMP_SKIP_X0_EN` defined: sweep starts at x1; 31 words emitted (x1..x31), full dump 62 cycles.
- Not defined: sweep starts at x0; 32 words emitted, first word `out_addr`=0, `out_data`=0.

## Test plan
- Preload x1=0x12345678, x2=0xAABBCCDD, x31=0x5555AAAA; `start`, `halt_ack` tied high, `out_ready`=1 -> 32 words (31 with macro) in index order with those values, others 0; `done`=1, `aborted`=0; 64 cycles READ..DONE.
- `out_ready` low 3 cycles while x2 presented -> `out_data`=0xAABBCCDD, `out_addr`=2 stable throughout; x3 follows only after handshake.
- `halt_ack` delayed 5 cycles after `start` -> `halt_req` high, `rf_read_enable`=0, no `out_valid` until ack; sweep then normal.
- `halt_ack` dropped while x4 in SEND -> next cycle `done`=1, `aborted`=1, `out_valid`=0, `halt_req`=0; following cycle IDLE.
- `start` pulsed mid-dump -> ignored, exactly one dump; `rst` asserted mid-dump -> all outputs 0 same cycle, no `done`; fresh `start` after release runs a complete dump.
